// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, write-back source select and ALU op encodings.
// Imported by the register file, the write-back mux and the bus interface.
package core_pkg;

  localparam int DATA_W = 4;
  localparam int NREGS  = 16;
  localparam int ADDR_W = $clog2(NREGS);

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_IMM  = 2'b10,
    WB_NONE = 2'b11
  } wb_sel_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SHL = 3'b101,
    ALU_SHR = 3'b110,
    ALU_PASS_B = 3'b111
  } alu_op_t;

endpackage

// File: rtl/reg_file_wb_if.sv
// Bus between the core datapath (master) and the register file / write-back stage (slave).
interface reg_file_wb_if import core_pkg::*; #(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
);

  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic          we;
  logic [AW-1:0] rd_addr;
  wb_sel_t       wb_sel;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] imm;
  logic [DW-1:0] wb_data;
  logic          flag_z;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;

  modport master (
    output rs1_addr, rs2_addr, we, rd_addr, wb_sel, alu_result, mem_rdata, imm, dbg_addr,
    input  rs1_data, rs2_data, wb_data, flag_z, dbg_data
  );

  modport slave (
    input  rs1_addr, rs2_addr, we, rd_addr, wb_sel, alu_result, mem_rdata, imm, dbg_addr,
    output rs1_data, rs2_data, wb_data, flag_z, dbg_data
  );

endinterface

// File: rtl/reg_file_wb_wb_mux.sv
// Write-back source select; wb_valid drops for the reserved encoding, which also forces 0.
module wb_mux import core_pkg::*; #(
  parameter int WIDTH = DATA_W
) (
  input  wb_sel_t            wb_sel,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic [WIDTH-1:0]   mem_rdata,
  input  logic [WIDTH-1:0]   imm,
  output logic [WIDTH-1:0]   wb_data,
  output logic               wb_valid
);

  always_comb begin
    wb_data  = '0;
    wb_valid = 1'b0;
    unique case (wb_sel)
      WB_ALU: begin
        wb_data  = alu_result;
        wb_valid = 1'b1;
      end
      WB_MEM: begin
        wb_data  = mem_rdata;
        wb_valid = 1'b1;
      end
      WB_IMM: begin
        wb_data  = imm;
        wb_valid = 1'b1;
      end
      default: begin
        wb_data  = '0;
        wb_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/reg_file_wb.sv
// Architectural register file with one write-back port, two operand read ports and a debug port.
// Register 0 reads as zero; reads never bypass a same-cycle write (would loop through the ALU).
module reg_file_wb #(
  parameter int DATA_W = core_pkg::DATA_W,
  parameter int NREGS  = core_pkg::NREGS,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_file_wb_if.slave         bus
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              flag_z_q;
  logic              flag_z_d;
  logic [DATA_W-1:0] wb_data;
  logic              wb_valid;
  logic              commit;

  wb_mux #(.WIDTH(DATA_W)) u_wb_mux (
    .wb_sel     (bus.wb_sel),
    .alu_result (bus.alu_result),
    .mem_rdata  (bus.mem_rdata),
    .imm        (bus.imm),
    .wb_data    (wb_data),
    .wb_valid   (wb_valid)
  );

  assign bus.wb_data = wb_data;
  assign bus.flag_z  = flag_z_q;

  // Writes to x0 or beyond the last register are dropped and leave the flag alone.
  always_comb begin
    regs_d   = regs_q;
    flag_z_d = flag_z_q;
    commit   = bus.we && wb_valid && (bus.rd_addr != '0) && (int'(bus.rd_addr) < NREGS);
    if (commit) begin
      regs_d[bus.rd_addr] = wb_data;
      flag_z_d            = (wb_data == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      flag_z_q <= 1'b1;
    end else begin
      regs_q   <= regs_d;
      flag_z_q <= flag_z_d;
    end
  end

  always_comb begin
    bus.rs1_data = '0;
    if ((bus.rs1_addr != '0) && (int'(bus.rs1_addr) < NREGS)) begin
      bus.rs1_data = regs_q[bus.rs1_addr];
    end
  end

  always_comb begin
    bus.rs2_data = '0;
    if ((bus.rs2_addr != '0) && (int'(bus.rs2_addr) < NREGS)) begin
      bus.rs2_data = regs_q[bus.rs2_addr];
    end
  end

  always_comb begin
    bus.dbg_data = '0;
    if ((bus.dbg_addr != '0) && (int'(bus.dbg_addr) < NREGS)) begin
      bus.dbg_data = regs_q[bus.dbg_addr];
    end
  end

endmodule

// File: tb/tb_reg_file_wb.sv
// Table-driven bench for reg_file_wb: each row drives one cycle, checks wb_data and the
// pre-edge read, and queues the post-edge expectations for comparison after the edge.
module tb_reg_file_wb;
  import core_pkg::*;

  typedef struct {
    logic       rst;
    logic       we;
    logic [3:0] rd;
    wb_sel_t    sel;
    logic [3:0] alu;
    logic [3:0] mem;
    logic [3:0] imm;
    logic [3:0] a1;
    logic [3:0] a2;
    logic [3:0] ad;
    logic [3:0] e_wb;
    logic [3:0] e_pre;
    logic [3:0] e_rs1;
    logic [3:0] e_rs2;
    logic [3:0] e_dbg;
    logic       e_z;
  } vec_t;

  typedef struct {
    int         row;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] dbg;
    logic       z;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  vec_t vecs[16];

  reg_file_wb_if bus();

  reg_file_wb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input int row, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s row %0d: actual=%h required=%h", name, row, act, exp);
    end
  endtask

  task automatic applyStimulus(input int row, input vec_t v);
    exp_t e;
    @(negedge clk);
    rst            = v.rst;
    bus.we         = v.we;
    bus.rd_addr    = v.rd;
    bus.wb_sel     = v.sel;
    bus.alu_result = v.alu;
    bus.mem_rdata  = v.mem;
    bus.imm        = v.imm;
    bus.rs1_addr   = v.a1;
    bus.rs2_addr   = v.a2;
    bus.dbg_addr   = v.ad;
    #1;
    check("wb_data", row, bus.wb_data, v.e_wb);
    check("rs1_pre_edge", row, bus.rs1_data, v.e_pre);
    e.row = row;
    e.rs1 = v.e_rs1;
    e.rs2 = v.e_rs2;
    e.dbg = v.e_dbg;
    e.z   = v.e_z;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_underflow: actual=0 entries required=1");
    end else begin
      e = sb_q.pop_front();
      check("rs1_data", e.row, bus.rs1_data, e.rs1);
      check("rs2_data", e.row, bus.rs2_data, e.rs2);
      check("dbg_data", e.row, bus.dbg_data, e.dbg);
      check("flag_z", e.row, {3'b000, bus.flag_z}, {3'b000, e.z});
    end
  endtask

  initial begin
    vec_t rv;
    int   n;
    //            rst   we    rd     sel      alu    mem    imm    a1     a2     ad     wb     pre    rs1    rs2    dbg    z
    vecs[0]  = '{1'b0, 1'b1, 4'h5, WB_ALU,  4'h7, 4'h0, 4'h0, 4'h5, 4'h0, 4'h5, 4'h7, 4'h0, 4'h7, 4'h0, 4'h7, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'h1, WB_MEM,  4'hE, 4'h3, 4'h9, 4'h1, 4'h5, 4'h1, 4'h3, 4'h0, 4'h3, 4'h7, 4'h3, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 4'h2, WB_IMM,  4'h1, 4'h2, 4'hF, 4'h2, 4'h1, 4'h2, 4'hF, 4'h0, 4'hF, 4'h3, 4'hF, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 4'h1, WB_NONE, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h1, 4'h0, 4'h3, 4'h3, 4'hF, 4'h3, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 4'h0, WB_ALU,  4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 4'h4, WB_ALU,  4'h0, 4'h5, 4'h5, 4'h4, 4'h5, 4'h4, 4'h0, 4'h0, 4'h0, 4'h7, 4'h0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 4'h0, WB_IMM,  4'h0, 4'h0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 4'h6, WB_ALU,  4'h1, 4'h0, 4'h0, 4'h6, 4'h4, 4'h6, 4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 4'h6, WB_ALU,  4'h0, 4'h0, 4'h0, 4'h6, 4'h2, 4'h5, 4'h0, 4'h1, 4'h1, 4'hF, 4'h7, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 4'h7, WB_ALU,  4'hC, 4'h0, 4'h0, 4'h7, 4'h8, 4'h7, 4'hC, 4'h0, 4'hC, 4'h0, 4'hC, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 4'h8, WB_MEM,  4'h0, 4'h2, 4'h0, 4'h7, 4'h8, 4'h8, 4'h2, 4'hC, 4'hC, 4'h2, 4'h2, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 4'h7, WB_ALU,  4'h5, 4'h0, 4'h0, 4'h7, 4'h8, 4'h7, 4'h5, 4'hC, 4'hC, 4'h2, 4'hC, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 4'h7, WB_IMM,  4'h0, 4'h0, 4'h3, 4'h7, 4'h7, 4'h7, 4'h3, 4'hC, 4'h3, 4'h3, 4'h3, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 4'h7, WB_MEM,  4'h0, 4'hE, 4'h0, 4'h7, 4'h7, 4'h7, 4'hE, 4'h3, 4'hE, 4'hE, 4'hE, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 4'hF, WB_IMM,  4'h0, 4'h0, 4'hB, 4'hF, 4'hE, 4'hF, 4'hB, 4'h0, 4'hB, 4'h0, 4'hB, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 4'h9, WB_ALU,  4'h6, 4'h0, 4'h0, 4'h7, 4'hF, 4'h5, 4'h6, 4'hE, 4'h0, 4'h0, 4'h0, 1'b1};

    rst            = 1'b1;
    bus.we         = 1'b0;
    bus.rd_addr    = '0;
    bus.wb_sel     = WB_NONE;
    bus.alu_result = '0;
    bus.mem_rdata  = '0;
    bus.imm        = '0;
    bus.rs1_addr   = '0;
    bus.rs2_addr   = '0;
    bus.dbg_addr   = '0;
    @(posedge clk);
    #1;

    // Reset held against a concurrent write to r3: the write must lose.
    rv = '{1'b1, 1'b1, 4'h3, WB_ALU, 4'hA, 4'h0, 4'h0, 4'h3, 4'h0, 4'h3, 4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1};
    applyStimulus(100, rv);
    checkOutput();

    $display("[TB] running %0d table rows", 16);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(i, vecs[i]);
      checkOutput();
    end

    // After the mid-sequence reset every register must read back as zero.
    @(negedge clk);
    rst    = 1'b0;
    bus.we = 1'b0;
    n = 0;
    for (int r = 0; r < 16; r++) begin
      bus.dbg_addr = 4'(r);
      bus.rs1_addr = 4'(r);
      bus.rs2_addr = 4'(15 - r);
      #1;
      check("post_reset_dbg", 200 + r, bus.dbg_data, 4'h0);
      check("post_reset_rs1", 200 + r, bus.rs1_data, 4'h0);
      check("post_reset_rs2", 200 + r, bus.rs2_data, 4'h0);
      n++;
    end
    check("post_reset_flag_z", 216, {3'b000, bus.flag_z}, 4'h1);
    check("post_reset_sweep_len", 217, 4'(n), 4'h0);

    check("scoreboard_leftover", 218, 4'(sb_q.size()), 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
